// File: rtl/tri_bus_pkg.sv
// tri_bus_pkg: shared types and helpers for the tri-state bus arbiter.
//   state_t : FSM encoding (IDLE=0, GRANT=1, TURN=2)
//   idx_w() : index width for a count of n items (never below 1 bit)
package tri_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr.sv
// rr_arbiter: combinational rotate-priority pick for the tri-state bus arbiter.
//   req    in  N   request vector
//   ptr    in  IW  last owner; search starts at ptr+1 and wraps
//   onehot out N   one-hot winner (all zero when no request)
//   idx    out IW  winner index (0 when no request)
//   found  out 1   any request present
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          found
);

   logic [IW-1:0] cand;

   // Walk from ptr+1 round to ptr itself, so the last owner is checked last.
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      cand   = '0;
      for (int i = 1; i <= N; i++) begin
         cand = IW'((int'(ptr) + i) % N);
         if (!found && req[cand]) begin
            found        = 1'b1;
            onehot[cand] = 1'b1;
            idx          = cand;
         end
      end
   end

endmodule

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter: round-robin owner selection for a shared tri-state bus with
// a guaranteed all-off turnaround gap between owners.
//   clk, rst     clock, asynchronous active-high reset
//   req          per-requester bus request (level)
//   req_data     requester data, slice k = [k*DATA_W +: DATA_W]
//   grant, sel   one-hot owner / buffer output-enable (identical, registered)
//   din          registered owner data for the buffer inputs
//   bus_busy     high while in GRANT or TURN
//   timeout_err  one-cycle pulse on a forced release
// Optional macro TRI_BUS_TIMEOUT_EN adds a MAX_HOLD hold limit per owner;
// without it an owner holds indefinitely and timeout_err stays 0.
module tri_bus_arbiter
   import tri_bus_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 1,
   parameter int TURN_CYC = 1,
   parameter int MAX_HOLD = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        sel,
   output logic [DATA_W-1:0]       din,
   output logic                    bus_busy,
   output logic                    timeout_err
);

   localparam int IW = idx_w(N_REQ);
   localparam int TW = idx_w(TURN_CYC);

   state_t            state, next_state;
   logic [IW-1:0]     ptr, pick_idx;
   logic [N_REQ-1:0]  pick_oh, sel_q, sel_n;
   logic              pick_any, owner_req, force_rel, turn_done, take, keep;
   logic [DATA_W-1:0] data_arr [N_REQ];
   logic [DATA_W-1:0] din_n;
   logic [TW-1:0]     turn_cnt;

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign data_arr[k] = req_data[k*DATA_W +: DATA_W];
   end

   rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
      .req    (req),
      .ptr    (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .found  (pick_any)
   );

   // ptr doubles as the current owner index while in GRANT.
   assign owner_req = req[ptr];
   assign turn_done = turn_cnt == TW'(TURN_CYC - 1);

`ifdef TRI_BUS_TIMEOUT_EN
   localparam int HW = idx_w(MAX_HOLD);
   logic [HW-1:0] hold_cnt;

   // Counts completed GRANT cycles; zero on the first cycle of each grant.
   always_ff @(posedge clk or posedge rst)
      if (rst) hold_cnt <= '0;
      else     hold_cnt <= (state == GRANT) ? hold_cnt + 1'b1 : '0;

   // An owner dropping req on its last allowed cycle is a normal release.
   assign force_rel = (state == GRANT) && owner_req && (hold_cnt == HW'(MAX_HOLD - 1));
`else
   assign force_rel = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= next_state;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = pick_any ? GRANT : IDLE;
         GRANT:   next_state = (!owner_req || force_rel) ? TURN : GRANT;
         TURN:    next_state = turn_done ? IDLE : TURN;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      take  = (state == IDLE) && pick_any;
      keep  = (state == GRANT) && (next_state == GRANT);
      sel_n = take ? pick_oh : keep ? sel_q : '0;
      din_n = take ? data_arr[pick_idx] : keep ? data_arr[ptr] : '0;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sel_q       <= '0;
         din         <= '0;
         bus_busy    <= 1'b0;
         timeout_err <= 1'b0;
         ptr         <= IW'(N_REQ - 1);
         turn_cnt    <= '0;
      end else begin
         sel_q       <= sel_n;
         din         <= din_n;
         bus_busy    <= next_state != IDLE;
         timeout_err <= force_rel;
         ptr         <= take ? pick_idx : ptr;
         turn_cnt    <= (state == TURN) ? turn_cnt + 1'b1 : '0;
      end

   assign sel   = sel_q;
   assign grant = sel_q;

endmodule
